fwd_hazard_unit: RTL and testbench

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_pkg.sv | 18 +
 rtl/fwd_src_lookup.sv | 49 ++++
 rtl/fwd_hazard_unit.sv | 87 ++++++++
 tb/tb_fwd_hazard_unit.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared constants, producer record type and tnew helper for fwd_hazard_unit
package fwd_pkg;

  localparam int REG_AW = 5;
  localparam int TNEW_W = 2;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic [TNEW_W-1:0] tnew;
  } fwd_rec_t;

  // A producer's remaining latency shrinks by one per stage, never below zero.
  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/fwd_src_lookup.sv
// rtl/fwd_src_lookup.sv - per-source producer match, youngest-wins priority and operand select
module fwd_src_lookup
  import fwd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 3,
  parameter int SEL_W  = 2
) (
  input  fwd_rec_t [DEPTH-1:0]        recs,
  input  logic [REG_AW-1:0]           src_addr,
  input  logic [TNEW_W-1:0]           src_tuse,
  input  logic [DATA_W-1:0]           rf_data,
  input  logic [DEPTH*DATA_W-1:0]     stg_data,
  output logic                        src_stall,
  output logic [SEL_W-1:0]            sel,
  output logic [DATA_W-1:0]           data
);

  logic              found;
  logic [TNEW_W-1:0] win_tnew;
  logic [SEL_W-1:0]  win_sel;
  logic [DATA_W-1:0] win_data;

  always_comb begin
    found    = 1'b0;
    win_tnew = '0;
    win_sel  = '0;
    win_data = '0;
    // Scan from the youngest stage; the first hit shadows older producers.
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && recs[i].valid && (recs[i].dest == src_addr) && (src_addr != '0)) begin
        found    = 1'b1;
        win_tnew = recs[i].tnew;
        win_sel  = SEL_W'(i + 1);
        win_data = stg_data[i*DATA_W +: DATA_W];
      end
    end

    src_stall = found && (win_tnew > src_tuse);
    if (found && (win_tnew == '0)) begin
      sel  = win_sel;
      data = win_data;
    end else begin
      sel  = '0;
      data = rf_data;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding and stall control; FWD_HAZARD_MD_BUSY_EN adds multiply/divide busy stall
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int MD_LAT  = 5
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   d_valid,
  input  logic [4:0]                             d_dest,
  input  logic [1:0]                             d_tnew,
  input  logic [NUM_SRC*5-1:0]                   src_addr,
  input  logic [NUM_SRC*2-1:0]                   src_tuse,
  input  logic [NUM_SRC*DATA_W-1:0]              src_rf_data,
  input  logic [DEPTH*DATA_W-1:0]                stg_data,
  input  logic                                   md_start,
  input  logic                                   md_use,
  output logic                                   stall,
  output logic [NUM_SRC*$clog2(DEPTH+1)-1:0]     fwd_sel,
  output logic [NUM_SRC*DATA_W-1:0]              fwd_data
);

  localparam int SEL_W = $clog2(DEPTH + 1);

  fwd_rec_t [DEPTH-1:0] rec;
  logic [NUM_SRC-1:0]   src_stall;
  logic                 md_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rec <= '0;
    end else begin
      // A stalled D instruction stays put, so E receives a bubble.
      rec[0] <= stall ? '0 : '{valid: d_valid, dest: d_dest, tnew: d_tnew};
      for (int i = 1; i < DEPTH; i++) begin
        rec[i] <= '{valid: rec[i-1].valid, dest: rec[i-1].dest, tnew: tnew_dec(rec[i-1].tnew)};
      end
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_src_lookup #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .SEL_W (SEL_W)
    ) u_lookup (
      .recs     (rec),
      .src_addr (src_addr[s*REG_AW +: REG_AW]),
      .src_tuse (src_tuse[s*TNEW_W +: TNEW_W]),
      .rf_data  (src_rf_data[s*DATA_W +: DATA_W]),
      .stg_data (stg_data),
      .src_stall(src_stall[s]),
      .sel      (fwd_sel[s*SEL_W +: SEL_W]),
      .data     (fwd_data[s*DATA_W +: DATA_W])
    );
  end

`ifdef FWD_HAZARD_MD_BUSY_EN
  localparam int MD_W = $clog2(MD_LAT + 1);

  logic [MD_W-1:0] md_cnt;

  // A start held off by a stall never reloads, so a busy unit cannot be restarted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_cnt <= '0;
    end else if (md_start && !stall) begin
      md_cnt <= MD_W'(MD_LAT);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

  assign md_stall = md_use && (md_cnt != '0);
`else
  logic unused_md;

  assign unused_md = md_start | md_use | (MD_LAT == 0);
  assign md_stall  = 1'b0;
`endif

  assign stall = (|src_stall) | md_stall;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed and randomized checks of fwd_hazard_unit against a producer-age model
module tb_fwd_hazard_unit;

  localparam int DATA_W  = 32;
  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 3;
  localparam int MD_LAT  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        reset_n;
  logic                        d_valid;
  logic [4:0]                  d_dest;
  logic [1:0]                  d_tnew;
  logic [NUM_SRC*5-1:0]        src_addr;
  logic [NUM_SRC*2-1:0]        src_tuse;
  logic [NUM_SRC*DATA_W-1:0]   src_rf_data;
  logic [DEPTH*DATA_W-1:0]     stg_data;
  logic                        md_start;
  logic                        md_use;
  logic                        stall;
  logic [NUM_SRC*2-1:0]        fwd_sel;
  logic [NUM_SRC*DATA_W-1:0]   fwd_data;

  int n_checks = 0;
  int n_fail   = 0;

  fwd_hazard_unit #(
    .DATA_W (DATA_W),
    .NUM_SRC(NUM_SRC),
    .DEPTH  (DEPTH),
    .MD_LAT (MD_LAT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .d_valid    (d_valid),
    .d_dest     (d_dest),
    .d_tnew     (d_tnew),
    .src_addr   (src_addr),
    .src_tuse   (src_tuse),
    .src_rf_data(src_rf_data),
    .stg_data   (stg_data),
    .md_start   (md_start),
    .md_use     (md_use),
    .stall      (stall),
    .fwd_sel    (fwd_sel),
    .fwd_data   (fwd_data)
  );

  // Model: each in-flight producer keeps its tnew at E entry; its stage index is its age.
  logic       m_valid [DEPTH];
  logic [4:0] m_dest  [DEPTH];
  logic [1:0] m_tnew0 [DEPTH];
  int         md_left;

  function automatic void ref_src(input int s, output logic stl, output logic [1:0] sel,
                                  output logic [31:0] data);
    logic [4:0] a;
    int         u;
    int         rem;
    a    = src_addr[s*5 +: 5];
    u    = int'(src_tuse[s*2 +: 2]);
    stl  = 1'b0;
    sel  = 2'd0;
    data = src_rf_data[s*32 +: 32];
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i] && m_dest[i] == a && a != 5'd0) begin
        rem = int'(m_tnew0[i]) - i;
        if (rem < 0) rem = 0;
        if (rem > u) stl = 1'b1;
        else if (rem == 0) begin
          sel  = 2'(i + 1);
          data = stg_data[i*32 +: 32];
        end
        break;
      end
    end
  endfunction

  function automatic logic ref_stall();
    logic        st;
    logic        s1;
    logic [1:0]  x;
    logic [31:0] y;
    st = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      ref_src(s, s1, x, y);
      st = st | s1;
    end
`ifdef FWD_HAZARD_MD_BUSY_EN
    if (md_use && md_left > 0) st = 1'b1;
`endif
    return st;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_valid[i] <= 1'b0;
        m_dest[i]  <= 5'd0;
        m_tnew0[i] <= 2'd0;
      end
      md_left <= 0;
    end else begin
      m_valid[0] <= ref_stall() ? 1'b0 : d_valid;
      m_dest[0]  <= d_dest;
      m_tnew0[0] <= d_tnew;
      for (int i = 1; i < DEPTH; i++) begin
        m_valid[i] <= m_valid[i-1];
        m_dest[i]  <= m_dest[i-1];
        m_tnew0[i] <= m_tnew0[i-1];
      end
`ifdef FWD_HAZARD_MD_BUSY_EN
      if (md_start && !ref_stall()) md_left <= MD_LAT;
      else if (md_left > 0) md_left <= md_left - 1;
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_valid  = 1'b0;
    d_dest   = 5'd0;
    d_tnew   = 2'd0;
    src_addr = '0;
    src_tuse = '0;
    md_start = 1'b0;
    md_use   = 1'b0;
  endtask

  task automatic flush();
    idle();
    repeat (8) tick();
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    idle();
    d_valid     = 1'b1;
    d_dest      = 5'd7;
    d_tnew      = 2'd3;
    src_addr    = {5'd3, 5'd7};
    src_tuse    = 4'd0;
    src_rf_data = 64'h1111_2222_AAAA_5555;
    stg_data    = {32'hC0C0_0003, 32'hC0C0_0002, 32'hC0C0_0001};
    for (int k = 0; k < 3; k++) begin
      #3;
      n_checks++;
      if (stall !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_stall[%0d]: got %0b want 0", k, stall);
      end
      n_checks++;
      if (fwd_sel !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_sel[%0d]: got %h want 0", k, fwd_sel);
      end
      n_checks++;
      if (fwd_data !== 64'h1111_2222_AAAA_5555) begin
        n_fail++;
        $display("FAIL reset_data[%0d]: got %h want 1111_2222_aaaa_5555", k, fwd_data);
      end
      @(posedge clk);
    end
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_forward_e();
    flush();
    stg_data = {32'h3333_0000, 32'h2222_0000, 32'hE0E0_0008};
    d_valid  = 1'b1;
    d_dest   = 5'd8;
    d_tnew   = 2'd0;
    tick();
    idle();
    src_addr = {5'd0, 5'd8};
    src_tuse = {2'd0, 2'd1};
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_e_stall: got %0b want 0", stall);
    end
    n_checks++;
    if (fwd_sel[1:0] !== 2'd1) begin
      n_fail++;
      $display("FAIL fwd_e_sel: got %0d want 1", fwd_sel[1:0]);
    end
    n_checks++;
    if (fwd_data[31:0] !== 32'hE0E0_0008) begin
      n_fail++;
      $display("FAIL fwd_e_data: got %h want e0e00008", fwd_data[31:0]);
    end
  endtask

  task automatic test_load_use();
    flush();
    stg_data = {32'hBEEF_0009, 32'h2222_0000, 32'h1111_0000};
    d_valid  = 1'b1;
    d_dest   = 5'd9;
    d_tnew   = 2'd2;
    tick();
    idle();
    src_addr = {5'd0, 5'd9};
    src_tuse = 4'd0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (stall !== 1'b1) begin
        n_fail++;
        $display("FAIL load_use_stall[%0d]: got %0b want 1", c, stall);
      end
      tick();
    end
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL load_use_release: got %0b want 0", stall);
    end
    n_checks++;
    if (fwd_sel[1:0] !== 2'd3 || fwd_data[31:0] !== 32'hBEEF_0009) begin
      n_fail++;
      $display("FAIL load_use_fwd_w: got sel %0d data %h want sel 3 data beef0009",
               fwd_sel[1:0], fwd_data[31:0]);
    end
  endtask

  task automatic test_youngest();
    flush();
    stg_data = {32'h0000_0C02, 32'h0000_0C01, 32'h0000_0C00};
    d_valid = 1'b1; d_dest = 5'd5; d_tnew = 2'd0;
    tick();
    d_valid = 1'b0;
    tick();
    d_valid = 1'b1;
    tick();
    idle();
    src_addr = {5'd5, 5'd5};
    #1;
    n_checks++;
    if (fwd_sel !== 4'b0101) begin
      n_fail++;
      $display("FAIL youngest_sel: got %b want 0101", fwd_sel);
    end
    n_checks++;
    if (fwd_data !== {32'h0000_0C00, 32'h0000_0C00}) begin
      n_fail++;
      $display("FAIL youngest_data: got %h want 00000c0000000c00", fwd_data);
    end
  endtask

  task automatic test_reg_zero();
    flush();
    src_rf_data = 64'd0;
    stg_data    = {32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
    d_valid = 1'b1; d_dest = 5'd0; d_tnew = 2'd3;
    tick();
    idle();
    src_addr = 10'd0;
    src_tuse = 4'd0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (stall !== 1'b0 || fwd_sel !== 4'd0 || fwd_data !== 64'd0) begin
        n_fail++;
        $display("FAIL reg_zero[%0d]: got stall %0b sel %b data %h want 0/0/0", c, stall, fwd_sel, fwd_data);
      end
      tick();
    end
  endtask

  task automatic test_md();
    flush();
    md_start = 1'b1;
    md_use   = 1'b1;
    tick();
`ifdef FWD_HAZARD_MD_BUSY_EN
    md_start = 1'b0;
    for (int c = 0; c <= MD_LAT + 1; c++) begin
      md_start = (c >= 1 && c <= 3);
      #1;
      n_checks++;
      if (stall !== (c < MD_LAT)) begin
        n_fail++;
        $display("FAIL md_busy[%0d]: got %0b want %0b", c, stall, (c < MD_LAT));
      end
      tick();
    end
`else
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (stall !== 1'b0) begin
        n_fail++;
        $display("FAIL md_ignored[%0d]: got %0b want 0", c, stall);
      end
      tick();
    end
`endif
    idle();
  endtask

  task automatic test_random();
    logic        es;
    logic        st;
    logic [1:0]  esel;
    logic [31:0] edata;
    flush();
    for (int n = 0; n < 400; n++) begin
      d_valid     = 1'($urandom_range(0, 1));
      d_dest      = 5'($urandom_range(0, 3));
      d_tnew      = 2'($urandom_range(0, 3));
      src_addr    = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      src_tuse    = 4'($urandom);
      src_rf_data = {$urandom, $urandom};
      stg_data    = {$urandom, $urandom, $urandom};
      md_start    = ($urandom_range(0, 9) == 0);
      md_use      = md_start | ($urandom_range(0, 4) == 0);
      #1;
      st = ref_stall();
      n_checks++;
      if (stall !== st) begin
        n_fail++;
        $display("FAIL rand_stall[%0d]: got %0b want %0b", n, stall, st);
      end
      for (int s = 0; s < NUM_SRC; s++) begin
        ref_src(s, es, esel, edata);
        n_checks++;
        if (fwd_sel[s*2 +: 2] !== esel || fwd_data[s*32 +: 32] !== edata) begin
          n_fail++;
          $display("FAIL rand_src%0d[%0d]: got sel %0d data %h want sel %0d data %h",
                   s, n, fwd_sel[s*2 +: 2], fwd_data[s*32 +: 32], esel, edata);
        end
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    flush();
    src_rf_data = 64'h0000_0000_1234_5678;
    stg_data    = {32'h9999_0002, 32'h9999_0001, 32'h9999_0000};
    d_valid = 1'b1; d_dest = 5'd9; d_tnew = 2'd2;
    tick();
    idle();
    src_addr = {5'd9, 5'd9};
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_pre_stall: got %0b want 1", stall);
    end
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (stall !== 1'b0 || fwd_sel !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got stall %0b sel %b want 0/0", stall, fwd_sel);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    src_tuse = 4'hF;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (stall !== 1'b0 || fwd_sel !== 4'd0 || fwd_data[31:0] !== 32'h1234_5678) begin
        n_fail++;
        $display("FAIL mid_reset_after[%0d]: got stall %0b sel %b data %h want 0/0/12345678",
                 c, stall, fwd_sel, fwd_data[31:0]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_forward_e();
    test_load_use();
    test_youngest();
    test_reg_zero();
    test_md();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
